ras_recover_ctrl: RTL and testbench
===================================

Name: ras_recover_ctrl

Overview:
Sequencer and recovery controller for the recursion-compressed return address stack (RAS) in the branch predictor.
- Front side: accepts speculative call/return requests from fetch and turns them into one-per-cycle stack push/pop strobes, with full/empty protection.
- Back side: keeps a committed shadow copy of the stack, updated by retired calls and returns.
- On a pipeline flush it reloads the speculative stack from the shadow in a fixed 2-cycle recovery sequence.

Parameters:
STACKDEEP, 16, physical stack entries; the controller uses entries 0..STACKDEEP-2 (15 usable).
STACKPTRW, 4, stack pointer width.
STACKWIDE, 32, return address width.
RECURCOUNT, 7, recursion counter width; saturates at 2^RECURCOUNT-1.

Ports:
Clk  in  1  clock, posedge.
Rest  in  1  synchronous active-low reset.
F_CALL  in  1  fetch predicts a call; push F_CALL_PC.
F_CALL_PC  in  STACKWIDE  return address to push.
F_RET  in  1  fetch predicts a return; pop.
F_CALL_ACK  out  1  call accepted this cycle (combinational).
F_RET_ACK  out  1  return accepted this cycle (combinational).
RET_PRED_VALID  out  1  registered; high 1 cycle after an accepted non-empty pop (stack DOUT valid).
C_CALL  in  1  committed call.
C_CALL_PC  in  STACKWIDE  committed return address.
C_RET  in  1  committed return.
C_READY  out  1  commit updates accepted (combinational, =state IDLE).
FLUSH  in  1  mispredict/exception flush, single-cycle pulse.
S_WABLE  out  1  stack push strobe.
S_RABLE  out  1  stack pop strobe.
S_DIN  out  STACKWIDE  push data.
S_FULL  in  1  stack full.
S_EMPTY  in  1  stack empty.
S_RELOAD  out  1  stack reload strobe.
S_RELOADPTR  out  STACKPTRW  reload pointer (shadow ptr).
S_RELOADLINES  out  15*(STACKWIDE+RECURCOUNT)  shadow entries; entry k at bits [k*(W+R) +: W+R], each {count, addr}.
BUSY  out  1  state != IDLE.
DROP_CNT  out  8  saturating count of dropped pushes (speculative or shadow).

Behaviour:
- Reset (Rest=0 at posedge): state IDLE; all shadow entries and shadow ptr = 0; RET_PRED_VALID=0; DROP_CNT=0. All strobes low while Rest=0. Reset overrides and aborts any recovery in progress.
- States:
  - IDLE: normal operation.
  - RELOAD: S_RELOAD=1 for exactly 1 cycle; S_RELOADPTR/S_RELOADLINES are the registered shadow. Always goes to SETTLE.
  - SETTLE: 1 cycle, no strobes, lets the stack absorb the reload. Always goes to IDLE.
- FLUSH sampled in IDLE -> RELOAD next cycle. In that same cycle: fetch acks forced 0; commit inputs still applied to the shadow (commits are older than the flush). FLUSH in RELOAD/SETTLE is ignored.
- Outside IDLE: F_CALL_ACK=F_RET_ACK=0, C_READY=0; requesters hold their requests. RET_PRED_VALID is forced to 0 in the cycle after entering RELOAD.
- Fetch arbitration, IDLE, no FLUSH, at most one strobe per cycle:
  - F_RET has priority. F_RET alone or with F_CALL -> F_RET_ACK=1. If !S_EMPTY, S_RABLE=1 and RET_PRED_VALID=1 next cycle; if S_EMPTY, no strobe and RET_PRED_VALID=0 next cycle (miss).
  - F_CALL without F_RET -> F_CALL_ACK=1. If !S_FULL, S_WABLE=1 and S_DIN=F_CALL_PC; if S_FULL, no strobe and DROP_CNT+1.
- Shadow update, when C_READY and C_CALL/C_RET; if both in one cycle, ret is applied first, then call, giving the combined next value:
  - pop: ptr==0 -> no change. Top count>1 -> count-1. Otherwise clear top entry and ptr-1.
  - push x: ptr!=0 and top.addr==x and count<max -> count+1. Otherwise if ptr<15 -> entry[ptr]={1,x}, ptr+1. Otherwise drop and DROP_CNT+1.
- DROP_CNT saturates at 255; two drops in one cycle count as +1 each.
- Latency: fetch ack is same cycle; stack strobe same cycle; RELOAD asserts 1 cycle after FLUSH; fetch resumes 3 cycles after FLUSH.

Test Plan:
1. Reset, then C_CALL pc=0x100, 0x200, 0x200 -> shadow ptr=2, entry1={count 2, 0x200}; FLUSH -> S_RELOAD high exactly 1 cycle later with S_RELOADPTR=2, entry0={1,0x100}; BUSY for 2 cycles.
2. F_CALL and F_RET together with stack non-empty -> F_RET_ACK=1, S_RABLE=1, F_CALL_ACK=0; next cycle F_CALL_ACK=1, S_WABLE=1, RET_PRED_VALID=1.
3. F_RET with S_EMPTY=1 -> ack=1, no S_RABLE, RET_PRED_VALID=0. F_CALL with S_FULL=1 -> ack=1, no S_WABLE, DROP_CNT 0->1.
4. Push 16 distinct committed calls -> shadow ptr stops at 15, DROP_CNT=1. Push 0x300 x130 at top -> count saturates at 127, then 3 further drops.
5. FLUSH with C_RET in the same cycle on shadow count=2 -> reload shows count=1. F_CALL during RELOAD/SETTLE -> no ack. Rest=0 during SETTLE -> IDLE, shadow cleared.

Source files
------------

// File: rtl/ras_recover_ctrl.sv
// Return-address-stack sequencer: arbitrates speculative push/pop from fetch,
// maintains a committed shadow stack and replays it into the stack after a flush.
module ras_recover_ctrl #(
    parameter int STACKDEEP  = 16,
    parameter int STACKPTRW  = 4,
    parameter int STACKWIDE  = 32,
    parameter int RECURCOUNT = 7
) (
    input  logic                                               Clk,
    input  logic                                               Rest,
    input  logic                                               F_CALL,
    input  logic [STACKWIDE-1:0]                               F_CALL_PC,
    input  logic                                               F_RET,
    output logic                                               F_CALL_ACK,
    output logic                                               F_RET_ACK,
    output logic                                               RET_PRED_VALID,
    input  logic                                               C_CALL,
    input  logic [STACKWIDE-1:0]                               C_CALL_PC,
    input  logic                                               C_RET,
    output logic                                               C_READY,
    input  logic                                               FLUSH,
    output logic                                               S_WABLE,
    output logic                                               S_RABLE,
    output logic [STACKWIDE-1:0]                               S_DIN,
    input  logic                                               S_FULL,
    input  logic                                               S_EMPTY,
    output logic                                               S_RELOAD,
    output logic [STACKPTRW-1:0]                               S_RELOADPTR,
    output logic [(STACKDEEP-1)*(STACKWIDE+RECURCOUNT)-1:0]    S_RELOADLINES,
    output logic                                               BUSY,
    output logic [7:0]                                         DROP_CNT
);
    localparam int NENT = STACKDEEP - 1;
    localparam int EW   = STACKWIDE + RECURCOUNT;
    localparam logic [STACKPTRW-1:0]  PTR_LAST = STACKPTRW'(NENT);
    localparam logic [STACKPTRW-1:0]  PTR_ONE  = STACKPTRW'(1);
    localparam logic [RECURCOUNT-1:0] CNT_MAX  = '1;
    localparam logic [RECURCOUNT-1:0] CNT_ONE  = RECURCOUNT'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RELOAD = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [STACKPTRW-1:0]  ptr_q, ptr_d, pop_ptr;
    logic [STACKWIDE-1:0]  addr_q [NENT];
    logic [STACKWIDE-1:0]  addr_d [NENT];
    logic [STACKWIDE-1:0]  pop_addr [NENT];
    logic [RECURCOUNT-1:0] cnt_q [NENT];
    logic [RECURCOUNT-1:0] cnt_d [NENT];
    logic [RECURCOUNT-1:0] pop_cnt [NENT];
    logic                  rpv_q, rpv_d;
    logic [7:0]            drop_q, drop_d;
    logic [8:0]            drop_sum;
    logic                  idle, fetch_en, c_en, fetch_drop, shadow_drop, top_hit;

    assign idle     = (state_q == ST_IDLE);
    assign fetch_en = Rest && idle && !FLUSH;
    assign c_en     = Rest && idle;

    // Return wins over call; a full/empty stack still acks so fetch never stalls.
    assign F_RET_ACK   = fetch_en && F_RET;
    assign F_CALL_ACK  = fetch_en && F_CALL && !F_RET;
    assign S_RABLE     = F_RET_ACK && !S_EMPTY;
    assign S_WABLE     = F_CALL_ACK && !S_FULL;
    assign fetch_drop  = F_CALL_ACK && S_FULL;
    assign S_DIN       = F_CALL_PC;
    assign rpv_d       = S_RABLE;

    assign C_READY        = idle;
    assign BUSY           = !idle;
    assign S_RELOAD       = Rest && (state_q == ST_RELOAD);
    assign S_RELOADPTR    = ptr_q;
    assign RET_PRED_VALID = rpv_q;
    assign DROP_CNT       = drop_q;

    genvar gi;
    generate
        for (gi = 0; gi < NENT; gi++) begin : g_pack
            assign S_RELOADLINES[gi*EW +: EW] = {cnt_q[gi], addr_q[gi]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (FLUSH) state_d = ST_RELOAD;
            ST_RELOAD: state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Shadow update: the committed return is applied first, the call sees its result.
    always_comb begin
        pop_ptr     = ptr_q;
        pop_addr    = addr_q;
        pop_cnt     = cnt_q;
        shadow_drop = 1'b0;
        top_hit     = 1'b0;
        if (c_en && C_RET && ptr_q != '0) begin
            for (int i = 0; i < NENT; i++) begin
                if (ptr_q == STACKPTRW'(i + 1)) begin
                    if (cnt_q[i] > CNT_ONE) begin
                        pop_cnt[i] = cnt_q[i] - CNT_ONE;
                    end else begin
                        pop_cnt[i]  = '0;
                        pop_addr[i] = '0;
                        pop_ptr     = ptr_q - PTR_ONE;
                    end
                end
            end
        end
        ptr_d  = pop_ptr;
        addr_d = pop_addr;
        cnt_d  = pop_cnt;
        if (c_en && C_CALL) begin
            for (int i = 0; i < NENT; i++) begin
                if (pop_ptr == STACKPTRW'(i + 1) && pop_addr[i] == C_CALL_PC &&
                    pop_cnt[i] != CNT_MAX) begin
                    cnt_d[i] = pop_cnt[i] + CNT_ONE;
                    top_hit  = 1'b1;
                end
            end
            if (!top_hit) begin
                if (pop_ptr < PTR_LAST) begin
                    for (int i = 0; i < NENT; i++) begin
                        if (pop_ptr == STACKPTRW'(i)) begin
                            addr_d[i] = C_CALL_PC;
                            cnt_d[i]  = CNT_ONE;
                        end
                    end
                    ptr_d = pop_ptr + PTR_ONE;
                end else begin
                    shadow_drop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        drop_sum = {1'b0, drop_q} + 9'(fetch_drop) + 9'(shadow_drop);
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge Clk) begin
        if (!Rest) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rpv_q   <= 1'b0;
            drop_q  <= '0;
            for (int i = 0; i < NENT; i++) begin
                addr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rpv_q   <= rpv_d;
            drop_q  <= drop_d;
            for (int i = 0; i < NENT; i++) begin
                addr_q[i] <= addr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_ras_recover_ctrl.sv
// Directed bench for ras_recover_ctrl: fetch arbitration, shadow bookkeeping,
// flush recovery sequence and drop counting.
module tb_ras_recover_ctrl;
    logic        Clk = 1'b0;
    logic        Rest, F_CALL, F_RET, C_CALL, C_RET, FLUSH, S_FULL, S_EMPTY;
    logic [31:0] F_CALL_PC, C_CALL_PC;
    logic        F_CALL_ACK, F_RET_ACK, RET_PRED_VALID, C_READY;
    logic        S_WABLE, S_RABLE, S_RELOAD, BUSY;
    logic [31:0] S_DIN;
    logic [3:0]  S_RELOADPTR;
    logic [584:0] S_RELOADLINES;
    logic [7:0]  DROP_CNT;

    int checks = 0;
    int errors = 0;

    ras_recover_ctrl dut (
        .Clk(Clk), .Rest(Rest),
        .F_CALL(F_CALL), .F_CALL_PC(F_CALL_PC), .F_RET(F_RET),
        .F_CALL_ACK(F_CALL_ACK), .F_RET_ACK(F_RET_ACK), .RET_PRED_VALID(RET_PRED_VALID),
        .C_CALL(C_CALL), .C_CALL_PC(C_CALL_PC), .C_RET(C_RET), .C_READY(C_READY),
        .FLUSH(FLUSH), .S_WABLE(S_WABLE), .S_RABLE(S_RABLE), .S_DIN(S_DIN),
        .S_FULL(S_FULL), .S_EMPTY(S_EMPTY), .S_RELOAD(S_RELOAD),
        .S_RELOADPTR(S_RELOADPTR), .S_RELOADLINES(S_RELOADLINES),
        .BUSY(BUSY), .DROP_CNT(DROP_CNT)
    );

    always #5 Clk = ~Clk;

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rest = 1'b0;
        cyc();
        Rest = 1'b1;
    endtask

    task automatic test_reset();
        Rest = 1'b0; F_CALL = 1'b1; F_RET = 1'b0; F_CALL_PC = 32'h55;
        C_CALL = 1'b0; C_RET = 1'b0; C_CALL_PC = '0; FLUSH = 1'b0;
        S_FULL = 1'b0; S_EMPTY = 1'b0;
        cyc(); cyc();
        checks++; if (F_CALL_ACK !== 1'b0 || S_WABLE !== 1'b0) begin errors++;
            $display("FAIL rst_strobe ack=%b wable=%b exp 0 0", F_CALL_ACK, S_WABLE); end
        checks++; if (BUSY !== 1'b0 || RET_PRED_VALID !== 1'b0 || DROP_CNT !== 8'd0) begin errors++;
            $display("FAIL rst_state busy=%b rpv=%b drop=%0d exp 0 0 0", BUSY, RET_PRED_VALID, DROP_CNT); end
        checks++; if (S_RELOADPTR !== 4'd0 || S_RELOADLINES !== '0 || S_RELOAD !== 1'b0) begin errors++;
            $display("FAIL rst_shadow ptr=%0d reload=%b exp 0 0", S_RELOADPTR, S_RELOAD); end
        F_CALL = 1'b0;
        Rest = 1'b1;
        cyc();
        $display("test_reset done");
    endtask

    task automatic test_flush_reload();
        C_CALL = 1'b1; C_CALL_PC = 32'h100; cyc();
        C_CALL_PC = 32'h200; cyc(); cyc();
        C_CALL = 1'b0;
        checks++; if (S_RELOADPTR !== 4'd2) begin errors++;
            $display("FAIL sh_ptr got %0d exp 2", S_RELOADPTR); end
        checks++; if (S_RELOADLINES[1*39 +: 39] !== {7'd2, 32'h200}) begin errors++;
            $display("FAIL sh_ent1 got %h exp %h", S_RELOADLINES[1*39 +: 39], {7'd2, 32'h200}); end
        FLUSH = 1'b1; F_CALL = 1'b1; F_CALL_PC = 32'h44; #1;
        checks++; if (F_CALL_ACK !== 1'b0 || S_WABLE !== 1'b0 || S_RELOAD !== 1'b0) begin errors++;
            $display("FAIL flush_cyc ack=%b wable=%b reload=%b exp 0 0 0", F_CALL_ACK, S_WABLE, S_RELOAD); end
        cyc(); FLUSH = 1'b0; #1;
        checks++; if (S_RELOAD !== 1'b1 || BUSY !== 1'b1 || C_READY !== 1'b0 || F_CALL_ACK !== 1'b0) begin errors++;
            $display("FAIL reload_cyc reload=%b busy=%b crdy=%b ack=%b exp 1 1 0 0", S_RELOAD, BUSY, C_READY, F_CALL_ACK); end
        checks++; if (S_RELOADPTR !== 4'd2 || S_RELOADLINES[0 +: 39] !== {7'd1, 32'h100}) begin errors++;
            $display("FAIL reload_data ptr=%0d ent0=%h exp 2 %h", S_RELOADPTR, S_RELOADLINES[0 +: 39], {7'd1, 32'h100}); end
        cyc();
        checks++; if (S_RELOAD !== 1'b0 || BUSY !== 1'b1 || F_CALL_ACK !== 1'b0) begin errors++;
            $display("FAIL settle_cyc reload=%b busy=%b ack=%b exp 0 1 0", S_RELOAD, BUSY, F_CALL_ACK); end
        cyc();
        checks++; if (BUSY !== 1'b0 || F_CALL_ACK !== 1'b1 || S_WABLE !== 1'b1) begin errors++;
            $display("FAIL resume busy=%b ack=%b wable=%b exp 0 1 1", BUSY, F_CALL_ACK, S_WABLE); end
        F_CALL = 1'b0;
        cyc();
        $display("test_flush_reload done");
    endtask

    task automatic test_arbitration();
        S_EMPTY = 1'b0; S_FULL = 1'b0;
        F_CALL = 1'b1; F_RET = 1'b1; F_CALL_PC = 32'hABC; #1;
        checks++; if (F_RET_ACK !== 1'b1 || S_RABLE !== 1'b1 || F_CALL_ACK !== 1'b0 || S_WABLE !== 1'b0) begin errors++;
            $display("FAIL arb_both rack=%b rable=%b cack=%b wable=%b exp 1 1 0 0", F_RET_ACK, S_RABLE, F_CALL_ACK, S_WABLE); end
        cyc(); F_RET = 1'b0; #1;
        checks++; if (F_CALL_ACK !== 1'b1 || S_WABLE !== 1'b1 || S_DIN !== 32'hABC || RET_PRED_VALID !== 1'b1) begin errors++;
            $display("FAIL arb_next cack=%b wable=%b din=%h rpv=%b exp 1 1 abc 1", F_CALL_ACK, S_WABLE, S_DIN, RET_PRED_VALID); end
        cyc(); F_CALL = 1'b0;
        checks++; if (RET_PRED_VALID !== 1'b0) begin errors++;
            $display("FAIL arb_rpv_clr got %b exp 0", RET_PRED_VALID); end
        $display("test_arbitration done");
    endtask

    task automatic test_empty_full();
        F_RET = 1'b1; S_EMPTY = 1'b0; cyc();
        S_EMPTY = 1'b1; #1;
        checks++; if (F_RET_ACK !== 1'b1 || S_RABLE !== 1'b0 || RET_PRED_VALID !== 1'b1) begin errors++;
            $display("FAIL empty_pop ack=%b rable=%b rpv=%b exp 1 0 1", F_RET_ACK, S_RABLE, RET_PRED_VALID); end
        cyc(); F_RET = 1'b0; S_EMPTY = 1'b0;
        checks++; if (RET_PRED_VALID !== 1'b0) begin errors++;
            $display("FAIL empty_rpv got %b exp 0", RET_PRED_VALID); end
        F_CALL = 1'b1; S_FULL = 1'b1; F_CALL_PC = 32'h77; #1;
        checks++; if (F_CALL_ACK !== 1'b1 || S_WABLE !== 1'b0 || DROP_CNT !== 8'd0) begin errors++;
            $display("FAIL full_push ack=%b wable=%b drop=%0d exp 1 0 0", F_CALL_ACK, S_WABLE, DROP_CNT); end
        cyc(); F_CALL = 1'b0; S_FULL = 1'b0;
        checks++; if (DROP_CNT !== 8'd1) begin errors++;
            $display("FAIL full_drop got %0d exp 1", DROP_CNT); end
        $display("test_empty_full done");
    endtask

    task automatic test_commit_pop();
        do_reset();
        C_RET = 1'b1; cyc(); C_RET = 1'b0;
        checks++; if (S_RELOADPTR !== 4'd0) begin errors++;
            $display("FAIL pop_empty ptr=%0d exp 0", S_RELOADPTR); end
        C_CALL = 1'b1; C_CALL_PC = 32'hA; cyc();
        C_CALL_PC = 32'hB; cyc(); cyc();
        C_RET = 1'b1; C_CALL_PC = 32'hC; cyc();
        C_CALL = 1'b0;
        checks++; if (S_RELOADPTR !== 4'd3 || S_RELOADLINES[1*39 +: 39] !== {7'd1, 32'hB} ||
                      S_RELOADLINES[2*39 +: 39] !== {7'd1, 32'hC}) begin errors++;
            $display("FAIL ret_then_call ptr=%0d e1=%h e2=%h exp 3 %h %h", S_RELOADPTR,
                     S_RELOADLINES[1*39 +: 39], S_RELOADLINES[2*39 +: 39], {7'd1, 32'hB}, {7'd1, 32'hC}); end
        cyc(); C_RET = 1'b0;
        checks++; if (S_RELOADPTR !== 4'd2 || S_RELOADLINES[2*39 +: 39] !== 39'd0) begin errors++;
            $display("FAIL pop_clear ptr=%0d e2=%h exp 2 0", S_RELOADPTR, S_RELOADLINES[2*39 +: 39]); end
        $display("test_commit_pop done");
    endtask

    task automatic test_shadow_overflow();
        do_reset();
        C_CALL = 1'b1;
        for (int i = 0; i < 16; i++) begin
            C_CALL_PC = 32'h1000 + 32'(i * 4);
            cyc();
        end
        C_CALL = 1'b0;
        checks++; if (S_RELOADPTR !== 4'd15 || DROP_CNT !== 8'd1 || S_RELOADLINES[14*39 +: 39] !== {7'd1, 32'h1038}) begin errors++;
            $display("FAIL ovf_distinct ptr=%0d drop=%0d e14=%h exp 15 1 %h", S_RELOADPTR, DROP_CNT,
                     S_RELOADLINES[14*39 +: 39], {7'd1, 32'h1038}); end
        do_reset();
        C_CALL = 1'b1;
        for (int i = 0; i < 14; i++) begin
            C_CALL_PC = 32'h2000 + 32'(i);
            cyc();
        end
        C_CALL_PC = 32'h300;
        for (int i = 0; i < 127; i++) cyc();
        checks++; if (S_RELOADPTR !== 4'd15 || DROP_CNT !== 8'd0 || S_RELOADLINES[14*39 +: 39] !== {7'd127, 32'h300}) begin errors++;
            $display("FAIL recur_sat ptr=%0d drop=%0d e14=%h exp 15 0 %h", S_RELOADPTR, DROP_CNT,
                     S_RELOADLINES[14*39 +: 39], {7'd127, 32'h300}); end
        for (int i = 0; i < 3; i++) cyc();
        C_CALL = 1'b0;
        checks++; if (DROP_CNT !== 8'd3 || S_RELOADLINES[14*39 +: 39] !== {7'd127, 32'h300}) begin errors++;
            $display("FAIL recur_drop drop=%0d e14=%h exp 3 %h", DROP_CNT, S_RELOADLINES[14*39 +: 39], {7'd127, 32'h300}); end
        // Shadow full with a new address and a full speculative stack: two drops per cycle.
        C_CALL = 1'b1; C_CALL_PC = 32'h999; F_CALL = 1'b1; S_FULL = 1'b1;
        cyc();
        checks++; if (DROP_CNT !== 8'd5) begin errors++;
            $display("FAIL double_drop got %0d exp 5", DROP_CNT); end
        for (int i = 0; i < 129; i++) cyc();
        C_CALL = 1'b0; F_CALL = 1'b0; S_FULL = 1'b0;
        checks++; if (DROP_CNT !== 8'd255) begin errors++;
            $display("FAIL drop_sat got %0d exp 255", DROP_CNT); end
        $display("test_shadow_overflow done");
    endtask

    task automatic test_flush_commit();
        do_reset();
        C_CALL = 1'b1; C_CALL_PC = 32'h500; cyc(); cyc();
        C_CALL = 1'b0;
        FLUSH = 1'b1; C_RET = 1'b1; F_CALL = 1'b1; #1;
        checks++; if (C_READY !== 1'b1 || F_CALL_ACK !== 1'b0) begin errors++;
            $display("FAIL flush_commit_cyc crdy=%b ack=%b exp 1 0", C_READY, F_CALL_ACK); end
        cyc(); FLUSH = 1'b0; C_RET = 1'b0;
        C_CALL = 1'b1; C_CALL_PC = 32'h777; #1;
        checks++; if (S_RELOAD !== 1'b1 || S_RELOADPTR !== 4'd1 || S_RELOADLINES[0 +: 39] !== {7'd1, 32'h500}) begin errors++;
            $display("FAIL flush_ret_reload rl=%b ptr=%0d e0=%h exp 1 1 %h", S_RELOAD, S_RELOADPTR,
                     S_RELOADLINES[0 +: 39], {7'd1, 32'h500}); end
        checks++; if (C_READY !== 1'b0 || F_CALL_ACK !== 1'b0 || RET_PRED_VALID !== 1'b0) begin errors++;
            $display("FAIL reload_block crdy=%b ack=%b rpv=%b exp 0 0 0", C_READY, F_CALL_ACK, RET_PRED_VALID); end
        cyc();
        checks++; if (BUSY !== 1'b1 || S_RELOADPTR !== 4'd1 || F_CALL_ACK !== 1'b0) begin errors++;
            $display("FAIL settle_block busy=%b ptr=%0d ack=%b exp 1 1 0", BUSY, S_RELOADPTR, F_CALL_ACK); end
        Rest = 1'b0; cyc();
        checks++; if (BUSY !== 1'b0 || S_RELOADPTR !== 4'd0 || S_RELOADLINES !== '0 || S_RELOAD !== 1'b0) begin errors++;
            $display("FAIL settle_reset busy=%b ptr=%0d rl=%b exp 0 0 0", BUSY, S_RELOADPTR, S_RELOAD); end
        C_CALL = 1'b0; F_CALL = 1'b0; Rest = 1'b1;
        cyc();
        $display("test_flush_commit done");
    endtask

    initial begin
        test_reset();
        test_flush_reload();
        test_arbitration();
        test_empty_full();
        test_commit_pop();
        test_shadow_overflow();
        test_flush_commit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
